wb_host_master: RTL

Wishbone classic single-cycle initiator: the master end of the bus our user-project slave answers on. It accepts one command at a time on a valid/ready port, runs one read or write cycle on the bus, and returns data or a timeout error on a response port. It is used by the self-test path to drive main_module's Wishbone slave from on-chip logic, and by the bench as a synthesizable bus driver.

---
 rtl/wb_host_master_if.sv | 41 ++++
 rtl/wb_host_master.sv | 77 +++++++
 2 files changed

// File: rtl/wb_host_master_if.sv
// Command/response port and Wishbone classic bus of the host master, bundled
// so that the initiator and whatever drives it share one set of signals.
interface wb_host_master_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);
  localparam int unsigned SelWidth = DATA_WIDTH / 8;

  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_we;
  logic [ADDR_WIDTH-1:0] cmd_adr;
  logic [DATA_WIDTH-1:0] cmd_dat;
  logic [SelWidth-1:0]   cmd_sel;

  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_dat;
  logic                  rsp_err;

  logic                  wbm_cyc_o;
  logic                  wbm_stb_o;
  logic                  wbm_we_o;
  logic [SelWidth-1:0]   wbm_sel_o;
  logic [ADDR_WIDTH-1:0] wbm_adr_o;
  logic [DATA_WIDTH-1:0] wbm_dat_o;
  logic                  wbm_ack_i;
  logic [DATA_WIDTH-1:0] wbm_dat_i;

  modport master (
    input  cmd_valid, cmd_we, cmd_adr, cmd_dat, cmd_sel, rsp_ready, wbm_ack_i, wbm_dat_i,
    output cmd_ready, rsp_valid, rsp_dat, rsp_err,
    output wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o
  );

  modport slave (
    output cmd_valid, cmd_we, cmd_adr, cmd_dat, cmd_sel, rsp_ready, wbm_ack_i, wbm_dat_i,
    input  cmd_ready, rsp_valid, rsp_dat, rsp_err,
    input  wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o
  );
endinterface

// File: rtl/wb_host_master.sv
// Wishbone classic single-cycle initiator: one command in, one bus cycle, one
// response (read data or timeout error) out. All outputs are registered.
module wb_host_master #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  wb_host_master_if.master  bus
);

  typedef enum logic [1:0] {StIdle, StBus, StResp} state_e;

  state_e     state;
  logic [7:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= StIdle;
      cnt           <= '0;
      bus.cmd_ready <= 1'b1;
      bus.rsp_valid <= 1'b0;
      bus.rsp_dat   <= '0;
      bus.rsp_err   <= 1'b0;
      bus.wbm_cyc_o <= 1'b0;
      bus.wbm_stb_o <= 1'b0;
      bus.wbm_we_o  <= 1'b0;
      bus.wbm_sel_o <= '0;
      bus.wbm_adr_o <= '0;
      bus.wbm_dat_o <= '0;
    end else begin
      unique case (state)
        StIdle: begin
          if (bus.cmd_valid) begin
            bus.wbm_we_o  <= bus.cmd_we;
            bus.wbm_adr_o <= bus.cmd_adr;
            bus.wbm_dat_o <= bus.cmd_dat;
            bus.wbm_sel_o <= bus.cmd_sel;
            bus.wbm_cyc_o <= 1'b1;
            bus.wbm_stb_o <= 1'b1;
            bus.cmd_ready <= 1'b0;
            cnt           <= '0;
            state         <= StBus;
          end
        end
        StBus: begin
          // Ack takes priority over an expiring counter in the same cycle.
          if (bus.wbm_ack_i) begin
            bus.wbm_cyc_o <= 1'b0;
            bus.wbm_stb_o <= 1'b0;
            bus.rsp_dat   <= bus.wbm_we_o ? '0 : bus.wbm_dat_i;
            bus.rsp_err   <= 1'b0;
            bus.rsp_valid <= 1'b1;
            state         <= StResp;
          end else if (cnt == 8'(TIMEOUT - 1)) begin
            bus.wbm_cyc_o <= 1'b0;
            bus.wbm_stb_o <= 1'b0;
            bus.rsp_dat   <= '0;
            bus.rsp_err   <= 1'b1;
            bus.rsp_valid <= 1'b1;
            state         <= StResp;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        StResp: begin
          if (bus.rsp_ready) begin
            bus.rsp_valid <= 1'b0;
            bus.cmd_ready <= 1'b1;
            state         <= StIdle;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule
